game_controller: RTL and testbench
==================================

# game_controller

Game-flow controller that drives the initiator side of the flood-fill engine's new-game and color-select handshakes. It generates a random initial board cell by cell into the initial-board storage and starts a game. It then forwards player color choices one at a time and scans the resulting game board to declare a win or a loss. It sits between the debounced button/switch front end and the flood-fill engine, on the engine's main CLOCK.

## Interface
- LFSR_SEED, 16'hACE1, reset value of the 16-bit board-generation LFSR (must be nonzero)
- CLOCK  in  1  system clock, same as the engine's CLOCK
- RESET  in  1  asynchronous, active-high reset
- SIZE  in  5  board edge length, sampled at new-game acceptance; clamped to 2..26
- COLOR_NUM  in  4  number of colors, sampled at new-game acceptance; clamped to 2..8
- MOVE_LIMIT  in  6  maximum moves, sampled at new-game acceptance; 0 is treated as 1
- NEW_GAME_REQ  in  1  one-cycle request pulse
- COLOR_REQ  in  1  one-cycle color-choice pulse
- COLOR_REQ_VAL  in  3  requested color
- INIT_WE  out  1  initial-board write strobe
- INIT_ROW, INIT_COL  out  5 each  write address
- INIT_COLOR  out  3  write data
- START_NEW_GAME  out  1  new-game request to the engine
- STARTED_GAME  in  1  engine acknowledge
- COLOR_SELECTED  out  3  color sent to the engine
- COLOR_SEL_SIG  out  1  color-select request
- CHANGING_COLOR  in  1  engine busy flag
- RD_ROW, RD_COL  out  5 each  game-board read address
- RD_COLOR  in  3  combinational read data from GAME_BOARD
- MOVE_COUNT  out  6  moves taken this game
- WON, LOST  out  1 each  game result flags
- BUSY  out  1  high in every state except IDLE, PLAY and OVER

## Operation
- **Reset values:** all outputs are 0; the state is IDLE; the LFSR equals LFSR_SEED.
- **LFSR:** 16-bit Galois, taps 16,14,13,11. It is free-running and advances every cycle in every state.
- **States:** IDLE, GEN, START, START_REL, PLAY, SEL, WAIT_DONE, SCAN, OVER.
- **IDLE / PLAY / OVER:** NEW_GAME_REQ is accepted only when STARTED_GAME=0 and CHANGING_COLOR=0.
  - On acceptance: latch the clamped SIZE/COLOR_NUM/MOVE_LIMIT, clear MOVE_COUNT/WON/LOST, set the cell pointer to (0,0), and go to GEN.
  - In all other states NEW_GAME_REQ is ignored.
- **GEN:** each cycle, let v = LFSR[2:0].
  - If v < COLOR_NUM: INIT_WE=1 with INIT_ROW/INIT_COL = current cell and INIT_COLOR = v, then advance the pointer row-major (col first; wrap col to 0 and increment row at SIZE-1).
  - Otherwise: INIT_WE=0 and the pointer holds (rejection sampling).
  - After the write of (SIZE-1,SIZE-1), go to START.
- **START:** START_NEW_GAME=1 until STARTED_GAME=1 is sampled, then START_REL.
- **START_REL:** START_NEW_GAME=0; wait for STARTED_GAME=0, then PLAY.
- **PLAY:**
  - RD address is held at (0,0).
  - A COLOR_REQ is accepted only if COLOR_REQ_VAL < COLOR_NUM and COLOR_REQ_VAL != RD_COLOR. Otherwise it is dropped silently.
  - On acceptance: COLOR_SELECTED <= COLOR_REQ_VAL, then SEL.
- **SEL:** COLOR_SEL_SIG=1 until CHANGING_COLOR=1 is sampled.
  - In that cycle: drop COLOR_SEL_SIG, increment MOVE_COUNT (saturating at 63), go to WAIT_DONE.
- **WAIT_DONE:** wait for CHANGING_COLOR=0, then SCAN with the pointer at (0,0).
- **SCAN:**
  - One cell per cycle; RD_ROW/RD_COL = pointer.
  - The first cycle captures the reference color from cell (0,0).
  - The first mismatch ends the scan early as not uniform.
  - After the (SIZE-1,SIZE-1) compare without a mismatch, the board is uniform.
  - If uniform: WON=1, go to OVER.
  - Else if MOVE_COUNT >= MOVE_LIMIT: LOST=1, go to OVER.
  - Else: go to PLAY.
- **OVER:** COLOR_REQ is ignored; WON/LOST hold until the next accepted new game.
- COLOR_SELECTED holds its last value outside SEL.

## Timing
- GEN write addresses are registered; each INIT_WE pulse lasts exactly one cycle.
- GEN takes at least SIZE*SIZE cycles; with COLOR_NUM=8 it takes exactly SIZE*SIZE.
- Handshake outputs are registered and change the cycle after the qualifying input is sampled.
- SCAN takes at most SIZE*SIZE cycles (676 for SIZE=26); RD_COLOR is sampled in the same cycle its address is presented.
- WON/LOST assert the cycle after the final SCAN compare.
- Reset during any state, including mid-handshake, forces IDLE and zero outputs immediately.
  - The engine has no reset, so a stale STARTED_GAME/CHANGING_COLOR blocks NEW_GAME_REQ acceptance until it falls.

## Test plan
- Reset asserted mid-GEN -> INIT_WE, START_NEW_GAME, COLOR_SEL_SIG, MOVE_COUNT, WON and LOST all 0 in the same cycle; state IDLE.
- NEW_GAME_REQ with SIZE=2, COLOR_NUM=8 -> 4 consecutive INIT_WE pulses at (0,0),(0,1),(1,0),(1,1); then START_NEW_GAME=1 until the model raises STARTED_GAME, then 0; BUSY falls when STARTED_GAME falls.
- SIZE=26, COLOR_NUM=3 -> exactly 676 INIT_WE pulses, all with INIT_COLOR <= 2, in strict row-major order.
- In PLAY with corner color 2: COLOR_REQ_VAL=2 -> no COLOR_SEL_SIG; COLOR_REQ_VAL=5 with COLOR_NUM=4 -> none; COLOR_REQ_VAL=1 -> COLOR_SELECTED=1, COLOR_SEL_SIG held until CHANGING_COLOR=1, MOVE_COUNT=1.
- Model board uniform after the move with SIZE=6 -> SCAN lasts 36 cycles, WON=1; a subsequent COLOR_REQ is ignored.
- MOVE_LIMIT=1, board non-uniform after the move -> LOST=1, WON=0; a new NEW_GAME_REQ clears both and MOVE_COUNT.

Source files
------------

// File: rtl/game_controller.sv
// Game-flow controller: fills the engine's initial board from an LFSR, runs the
// new-game and color-select handshakes, and scans the game board for win/loss.
module game_controller #(
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic       clock_i,
    input  logic       reset_i,
    input  logic [4:0] size_i,
    input  logic [3:0] color_num_i,
    input  logic [5:0] move_limit_i,
    input  logic       new_game_req_i,
    input  logic       color_req_i,
    input  logic [2:0] color_req_val_i,
    output logic       init_we_o,
    output logic [4:0] init_row_o,
    output logic [4:0] init_col_o,
    output logic [2:0] init_color_o,
    output logic       start_new_game_o,
    input  logic       started_game_i,
    output logic [2:0] color_selected_o,
    output logic       color_sel_sig_o,
    input  logic       changing_color_i,
    output logic [4:0] rd_row_o,
    output logic [4:0] rd_col_o,
    input  logic [2:0] rd_color_i,
    output logic [5:0] move_count_o,
    output logic       won_o,
    output logic       lost_o,
    output logic       busy_o
);

    typedef enum logic [3:0] {
        StIdle, StGen, StStart, StStartRel, StPlay, StSel, StWaitDone, StScan, StOver
    } state_e;

    state_e      state_q;
    logic [15:0] lfsr_q, lfsr_d;
    logic [4:0]  size_q;
    logic [3:0]  ncol_q;
    logic [5:0]  limit_q;
    logic [4:0]  row_q, col_q;
    logic [2:0]  ref_q;
    logic        init_we_q;
    logic [4:0]  init_row_q, init_col_q;
    logic [2:0]  init_color_q;
    logic        start_q;
    logic [2:0]  color_sel_q;
    logic        sel_sig_q;
    logic [5:0]  move_q;
    logic        won_q, lost_q;

    logic [4:0] size_clamp;
    logic [3:0] ncol_clamp;
    logic [5:0] limit_clamp;
    logic       new_game_ok, color_ok, gen_write;
    logic       row_last, col_last, scan_first, scan_mismatch;
    logic [2:0] scan_ref;

    // Galois form, taps 16,14,13,11
    always_comb begin
        lfsr_d = lfsr_q >> 1;
        if (lfsr_q[0]) begin
            lfsr_d = lfsr_d ^ 16'hB400;
        end
    end

    always_comb begin
        size_clamp  = (size_i < 5'd2) ? 5'd2 : ((size_i > 5'd26) ? 5'd26 : size_i);
        ncol_clamp  = (color_num_i < 4'd2) ? 4'd2 :
                      ((color_num_i > 4'd8) ? 4'd8 : color_num_i);
        limit_clamp = (move_limit_i == 6'd0) ? 6'd1 : move_limit_i;
        new_game_ok = new_game_req_i && !started_game_i && !changing_color_i;
        color_ok    = ({1'b0, color_req_val_i} < ncol_q) && (color_req_val_i != rd_color_i);
        gen_write   = {1'b0, lfsr_q[2:0]} < ncol_q;
        row_last    = row_q == size_q - 5'd1;
        col_last    = col_q == size_q - 5'd1;
        // Pointer only sits at (0,0) on the first scan cycle
        scan_first    = (row_q == 5'd0) && (col_q == 5'd0);
        scan_ref      = scan_first ? rd_color_i : ref_q;
        scan_mismatch = rd_color_i != scan_ref;
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q      <= StIdle;
            lfsr_q       <= LFSR_SEED;
            size_q       <= 5'd0;
            ncol_q       <= 4'd0;
            limit_q      <= 6'd0;
            row_q        <= 5'd0;
            col_q        <= 5'd0;
            ref_q        <= 3'd0;
            init_we_q    <= 1'b0;
            init_row_q   <= 5'd0;
            init_col_q   <= 5'd0;
            init_color_q <= 3'd0;
            start_q      <= 1'b0;
            color_sel_q  <= 3'd0;
            sel_sig_q    <= 1'b0;
            move_q       <= 6'd0;
            won_q        <= 1'b0;
            lost_q       <= 1'b0;
        end else begin
            lfsr_q    <= lfsr_d;
            init_we_q <= 1'b0;
            unique case (state_q)
                StIdle, StPlay, StOver: begin
                    if (new_game_ok) begin
                        size_q  <= size_clamp;
                        ncol_q  <= ncol_clamp;
                        limit_q <= limit_clamp;
                        move_q  <= 6'd0;
                        won_q   <= 1'b0;
                        lost_q  <= 1'b0;
                        row_q   <= 5'd0;
                        col_q   <= 5'd0;
                        state_q <= StGen;
                    end else if (state_q == StPlay && color_req_i && color_ok) begin
                        color_sel_q <= color_req_val_i;
                        sel_sig_q   <= 1'b1;
                        state_q     <= StSel;
                    end
                end
                StGen: begin
                    if (gen_write) begin
                        init_we_q    <= 1'b1;
                        init_row_q   <= row_q;
                        init_col_q   <= col_q;
                        init_color_q <= lfsr_q[2:0];
                        if (col_last) begin
                            col_q <= 5'd0;
                            if (row_last) begin
                                row_q   <= 5'd0;
                                start_q <= 1'b1;
                                state_q <= StStart;
                            end else begin
                                row_q <= row_q + 5'd1;
                            end
                        end else begin
                            col_q <= col_q + 5'd1;
                        end
                    end
                end
                StStart: begin
                    if (started_game_i) begin
                        start_q <= 1'b0;
                        state_q <= StStartRel;
                    end
                end
                StStartRel: begin
                    if (!started_game_i) begin
                        state_q <= StPlay;
                    end
                end
                StSel: begin
                    if (changing_color_i) begin
                        sel_sig_q <= 1'b0;
                        if (move_q != 6'd63) begin
                            move_q <= move_q + 6'd1;
                        end
                        state_q <= StWaitDone;
                    end
                end
                StWaitDone: begin
                    if (!changing_color_i) begin
                        row_q   <= 5'd0;
                        col_q   <= 5'd0;
                        state_q <= StScan;
                    end
                end
                StScan: begin
                    ref_q <= scan_ref;
                    if (scan_mismatch) begin
                        if (move_q >= limit_q) begin
                            lost_q  <= 1'b1;
                            state_q <= StOver;
                        end else begin
                            state_q <= StPlay;
                        end
                    end else if (row_last && col_last) begin
                        won_q   <= 1'b1;
                        state_q <= StOver;
                    end else if (col_last) begin
                        col_q <= 5'd0;
                        row_q <= row_q + 5'd1;
                    end else begin
                        col_q <= col_q + 5'd1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign init_we_o        = init_we_q;
    assign init_row_o       = init_row_q;
    assign init_col_o       = init_col_q;
    assign init_color_o     = init_color_q;
    assign start_new_game_o = start_q;
    assign color_selected_o = color_sel_q;
    assign color_sel_sig_o  = sel_sig_q;
    assign move_count_o     = move_q;
    assign won_o            = won_q;
    assign lost_o           = lost_q;
    assign rd_row_o         = (state_q == StScan) ? row_q : 5'd0;
    assign rd_col_o         = (state_q == StScan) ? col_q : 5'd0;
    assign busy_o           = !(state_q inside {StIdle, StPlay, StOver});

endmodule

// File: tb/tb_game_controller.sv
// Bench for game_controller: scripted engine model plus a cycle-level expectation
// model checked at every negative clock edge.
module tb_game_controller;

    localparam int PhIdle = 0;
    localparam int PhPlay = 1;
    localparam int PhOver = 2;

    logic       clock = 1'b0, reset = 1'b1;
    logic [4:0] size = '0;
    logic [3:0] color_num = '0;
    logic [5:0] move_limit = '0;
    logic       new_game_req = 1'b0, color_req = 1'b0;
    logic [2:0] color_req_val = '0;
    logic       init_we, start_new_game, color_sel_sig, won, lost, busy;
    logic [4:0] init_row, init_col, rd_row, rd_col;
    logic [2:0] init_color, color_selected, rd_color;
    logic       started_game = 1'b0, changing_color = 1'b0;
    logic [5:0] move_count;

    logic [2:0] board [0:25][0:25];

    game_controller #(.LFSR_SEED(16'hACE1)) dut (
        .clock_i(clock), .reset_i(reset), .size_i(size), .color_num_i(color_num),
        .move_limit_i(move_limit), .new_game_req_i(new_game_req), .color_req_i(color_req),
        .color_req_val_i(color_req_val), .init_we_o(init_we), .init_row_o(init_row),
        .init_col_o(init_col), .init_color_o(init_color), .start_new_game_o(start_new_game),
        .started_game_i(started_game), .color_selected_o(color_selected),
        .color_sel_sig_o(color_sel_sig), .changing_color_i(changing_color),
        .rd_row_o(rd_row), .rd_col_o(rd_col), .rd_color_i(rd_color),
        .move_count_o(move_count), .won_o(won), .lost_o(lost), .busy_o(busy)
    );

    always #5 clock = ~clock;

    assign rd_color = (rd_row < 5'd26 && rd_col < 5'd26) ? board[rd_row][rd_col] : 3'd0;

    int n_checks = 0, n_errors = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference LFSR, straight from the polynomial definition
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        logic [15:0] n;
        n = s >> 1;
        if (s[0]) n = n ^ 16'hB400;
        return n;
    endfunction

    logic [15:0] lfsr_m;
    always @(posedge clock or posedge reset) begin
        if (reset) lfsr_m <= 16'hACE1;
        else       lfsr_m <= lfsr_next(lfsr_m);
    end

    // Expected outputs for the current cycle
    bit chk_en = 1'b0;
    int e_we = 0, e_row = 0, e_col = 0, e_color = 0, e_start = 0, e_sel = 0, e_csel = 0;
    int e_move = 0, e_won = 0, e_lost = 0, e_busy = 0, e_rd_row = 0, e_rd_col = 0;
    int m_size = 2, m_ncol = 2, m_limit = 1, m_phase = PhIdle;

    always @(negedge clock) begin
        if (chk_en) begin
            check("init_we", init_we, e_we);
            if (e_we != 0) begin
                check("init_row", init_row, e_row);
                check("init_col", init_col, e_col);
                check("init_color", init_color, e_color);
            end
            check("start_new_game", start_new_game, e_start);
            check("color_sel_sig", color_sel_sig, e_sel);
            check("color_selected", color_selected, e_csel);
            check("move_count", move_count, e_move);
            check("won", won, e_won);
            check("lost", lost, e_lost);
            check("busy", busy, e_busy);
            check("rd_row", rd_row, e_rd_row);
            check("rd_col", rd_col, e_rd_col);
        end
    end

    int wr_cnt = 0;
    int log_row [0:7], log_col [0:7], log_color [0:7];
    always @(negedge clock) begin
        if (init_we) begin
            if (wr_cnt < 8) begin
                log_row[wr_cnt]   = init_row;
                log_col[wr_cnt]   = init_col;
                log_color[wr_cnt] = init_color;
            end
            wr_cnt = wr_cnt + 1;
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic board_random(input int corner);
        for (int r = 0; r < 26; r++)
            for (int c = 0; c < 26; c++)
                board[r][c] = 3'($urandom_range(0, 7));
        board[0][0] = 3'(corner);
    endtask

    // Engine's flood result: whole board in val, optionally with one stray cell
    task automatic paint(input int val, input bit uni);
        int n, idx;
        n = m_size * m_size;
        for (int i = 0; i < n; i++) board[i / m_size][i % m_size] = 3'(val);
        if (!uni) begin
            idx = $urandom_range(1, n - 1);
            board[idx / m_size][idx % m_size] = 3'((val + 1 + $urandom_range(0, 6)) % 8);
        end
    endtask

    task automatic new_game(input int s, input int c, input int l);
        int n, k, guard, d;
        logic [2:0] v;
        m_size  = (s < 2) ? 2 : ((s > 26) ? 26 : s);
        m_ncol  = (c < 2) ? 2 : ((c > 8) ? 8 : c);
        m_limit = (l == 0) ? 1 : l;
        n = m_size * m_size;
        size = 5'(s); color_num = 4'(c); move_limit = 6'(l);
        new_game_req = 1'b1;
        tick();
        new_game_req = 1'b0;
        e_move = 0; e_won = 0; e_lost = 0; e_busy = 1; e_we = 0; e_start = 0;
        k = 0; guard = 0;
        while (k < n && guard < 20000) begin
            v = lfsr_m[2:0];
            tick();
            guard++;
            e_we = (int'(v) < m_ncol) ? 1 : 0;
            e_row = k / m_size; e_col = k % m_size; e_color = int'(v);
            if (e_we != 0) begin
                k++;
                if (k == n) e_start = 1;
            end
        end
        if (k < n) check("gen_cycle_budget", k, n);
        d = $urandom_range(0, 3);
        repeat (d) begin tick(); e_we = 0; end
        started_game = 1'b1;
        tick();
        e_we = 0; e_start = 0;
        d = $urandom_range(0, 2);
        repeat (d) tick();
        started_game = 1'b0;
        tick();
        e_busy = 0;
        m_phase = PhPlay;
    endtask

    task automatic color_move(input int val, input bit uni);
        bit acc;
        int n, first_mm, cells, d;
        color_req = 1'b1; color_req_val = 3'(val);
        acc = (m_phase == PhPlay) && (val < m_ncol) && (val != int'(board[0][0]));
        tick();
        color_req = 1'b0;
        if (acc) begin
            e_sel = 1; e_csel = val; e_busy = 1;
            d = $urandom_range(0, 3);
            repeat (d) tick();
            changing_color = 1'b1;
            tick();
            e_sel = 0;
            if (e_move < 63) e_move++;
            paint(val, uni);
            d = $urandom_range(0, 2);
            repeat (d) tick();
            changing_color = 1'b0;
            tick();
            n = m_size * m_size;
            first_mm = n;
            for (int i = n - 1; i > 0; i--)
                if (board[i / m_size][i % m_size] != board[0][0]) first_mm = i;
            cells = (first_mm == n) ? n : first_mm + 1;
            for (int i = 0; i < cells; i++) begin
                if (i > 0) tick();
                e_rd_row = i / m_size; e_rd_col = i % m_size;
            end
            tick();
            e_rd_row = 0; e_rd_col = 0; e_busy = 0;
            if (first_mm == n) begin
                e_won = 1; m_phase = PhOver;
            end else if (e_move >= m_limit) begin
                e_lost = 1; m_phase = PhOver;
            end
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, val, s, c, l, tries;
        for (int r = 0; r < 26; r++)
            for (int cc = 0; cc < 26; cc++)
                board[r][cc] = 3'd0;
        tick(); tick();
        chk_en = 1'b1;
        check("reset_busy", busy, 0);
        check("reset_start", start_new_game, 0);
        check("reset_we", init_we, 0);

        // First game straight out of reset: LFSR colors hand-derived from 16'hACE1
        reset = 1'b0;
        base = wr_cnt;
        new_game(2, 8, 5);
        check("gameA_writes", wr_cnt - base, 4);
        check("gameA_w0", log_row[0] * 100 + log_col[0] * 10 + log_color[0], 0);
        check("gameA_w1", log_row[1] * 100 + log_col[1] * 10 + log_color[1], 10);
        check("gameA_w2", log_row[2] * 100 + log_col[2] * 10 + log_color[2], 104);
        check("gameA_w3", log_row[3] * 100 + log_col[3] * 10 + log_color[3], 116);

        // A stale engine flag blocks new-game acceptance
        changing_color = 1'b1;
        new_game_req = 1'b1;
        tick();
        new_game_req = 1'b0;
        tick();
        check("stale_block_busy", busy, 0);
        changing_color = 1'b0;
        tick();

        // Largest board, three colors
        base = wr_cnt;
        new_game(26, 3, 0);
        check("gameB_writes", wr_cnt - base, 676);

        // Move limit of one on a non-uniform result loses
        new_game(5, 5, 1);
        board_random(3);
        color_move(1, 1'b0);
        check("gameD_lost", lost, 1);
        check("gameD_won", won, 0);
        check("gameD_moves", move_count, 1);
        new_game(4, 4, 2);
        check("clear_lost", lost, 0);
        check("clear_moves", move_count, 0);

        // Corner color 2 on a 6x6 board with four colors
        new_game(6, 4, 3);
        board_random(2);
        color_move(2, 1'b0);
        check("same_color_dropped", move_count, 0);
        color_move(5, 1'b0);
        check("oob_color_dropped", move_count, 0);
        color_move(1, 1'b1);
        check("gameC_won", won, 1);
        check("gameC_colsel", color_selected, 1);
        check("gameC_moves", move_count, 1);
        color_move(3, 1'b1);
        check("over_ignores_color", move_count, 1);

        // Reset in the middle of board generation
        chk_en = 1'b0;
        size = 5'd8; color_num = 4'd8; move_limit = 6'd4;
        new_game_req = 1'b1;
        tick();
        new_game_req = 1'b0;
        repeat (3) tick();
        check("pre_rst_busy", busy, 1);
        check("pre_rst_we", init_we, 1);
        reset = 1'b1;
        #1;
        check("rst_we", init_we, 0);
        check("rst_busy", busy, 0);
        check("rst_colsel", color_selected, 0);
        check("rst_won", won, 0);
        e_we = 0; e_start = 0; e_sel = 0; e_csel = 0; e_move = 0; e_won = 0; e_lost = 0;
        e_busy = 0; e_rd_row = 0; e_rd_col = 0;
        m_phase = PhIdle;
        chk_en = 1'b1;
        tick();
        reset = 1'b0;
        tick();

        // Randomized games, including clamped parameters
        for (int g = 0; g < 8; g++) begin
            s = (g == 0) ? 31 : $urandom_range(0, 12);
            c = (g == 0) ? 8 : $urandom_range(0, 15);
            l = $urandom_range(0, 4);
            new_game(s, c, l);
            board_random($urandom_range(0, m_ncol - 1));
            tries = 0;
            while (m_phase == PhPlay && tries < 20) begin
                val = $urandom_range(0, 7);
                color_move(val, $urandom_range(0, 3) == 0);
                tick();
                tries++;
            end
        end

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
